// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks operands MSB chunk first, stopping at the first differing chunk.
// Latency: j cycles after accept for a decision using j chunks (1..NCHUNK).
// Backpressure: result held in DONE until out_ready; no new accept until released.
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             l,
  output logic             e,
  output logic             g,
  output logic [CW-1:0]    chunks_used
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             chunk_gt, chunk_lt, decide;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    chunk_a  = a_q[int'(idx)*CHUNK +: CHUNK];
    chunk_b  = b_q[int'(idx)*CHUNK +: CHUNK];
    chunk_gt = (chunk_a > chunk_b);
    chunk_lt = (chunk_a < chunk_b);
    decide   = chunk_gt || chunk_lt || (idx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_CMP;
      S_CMP:   if (decide) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Flipping the sign bit maps two's complement onto unsigned order, so one compare path serves both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      cnt         <= '0;
      l           <= 1'b0;
      e           <= 1'b0;
      g           <= 1'b0;
      chunks_used <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= sgn ? (a ^ MSB_MASK) : a;
            b_q <= sgn ? (b ^ MSB_MASK) : b;
            idx <= IW'(NCHUNK - 1);
            cnt <= '0;
          end
        end
        S_CMP: begin
          cnt <= cnt + CW'(1);
          if (decide) begin
            l           <= chunk_lt;
            g           <= chunk_gt;
            e           <= !chunk_lt && !chunk_gt;
            chunks_used <= cnt + CW'(1);
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator (WIDTH=16, CHUNK=4): vector table plus reset, backpressure and back-to-back sequences.
module tb_seq_mag_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sgn = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        l, e, g;
  logic [2:0]  chunks_used;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [2:0]  leg;
    logic [2:0]  cu;
  } vec_t;

  vec_t vecs[12];

  seq_mag_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
    .l(l), .e(e), .g(g), .chunks_used(chunks_used)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("idle reached", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int  lat;
    bit  seen;
    wait_idle();
    a = v.a; b = v.b; sgn = v.s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; sgn = ~v.s;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      seen = out_valid;
    end
    chk($sformatf("vec%0d latency", k), lat, {29'd0, v.cu});
    chk($sformatf("vec%0d leg", k), {29'd0, l, e, g}, {29'd0, v.leg});
    chk($sformatf("vec%0d chunks_used", k), {29'd0, chunks_used}, {29'd0, v.cu});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    // {a, b, sgn, {l,e,g}, chunks_used}
    vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 3'b010, 3'd4};
    vecs[1]  = '{16'h12A4, 16'h12B4, 1'b0, 3'b100, 3'd3};
    vecs[2]  = '{16'h9000, 16'h1FFF, 1'b0, 3'b001, 3'd1};
    vecs[3]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b001, 3'd1};
    vecs[4]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b100, 3'd1};
    vecs[5]  = '{16'hFFFF, 16'h0001, 1'b1, 3'b100, 3'd1};
    vecs[6]  = '{16'h0005, 16'h0003, 1'b0, 3'b001, 3'd4};
    vecs[7]  = '{16'h0003, 16'h0005, 1'b1, 3'b100, 3'd4};
    vecs[8]  = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b100, 3'd4};
    vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 3'b010, 3'd4};
    vecs[10] = '{16'h1200, 16'h1300, 1'b0, 3'b100, 3'd2};
    vecs[11] = '{16'h8000, 16'h8000, 1'b1, 3'b010, 3'd4};

    // Reset state
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset leg", {29'd0, l, e, g}, 32'd0);
    chk("reset chunks_used", {29'd0, chunks_used}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset asserted mid-CMP abandons the transaction
    begin
      bit seen = 0;
      wait_idle();
      a = 16'h1234; b = 16'h1234; sgn = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midcmp reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("midcmp reset in_ready", {31'd0, in_ready}, 32'd1);
      chk("midcmp reset leg", {29'd0, l, e, g}, 32'd0);
      chk("midcmp reset chunks_used", {29'd0, chunks_used}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      chk("no result after reset", {31'd0, seen}, 32'd0);
    end

    // Backpressure: result held, new in_valid ignored, in_ready back one cycle after release
    begin
      int  n = 0;
      bit  spurious = 0;
      wait_idle();
      out_ready = 1'b0;
      a = 16'h0005; b = 16'h0003; sgn = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      while (!out_valid && n < 20) begin
        @(posedge clk);
        #1 n++;
      end
      chk("bp latency", n, 32'd4);
      for (int i = 0; i < 5; i++) begin
        if (i == 2) begin
          a = 16'h0000; b = 16'h0000; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk($sformatf("bp hold out_valid c%0d", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("bp hold in_ready c%0d", i), {31'd0, in_ready}, 32'd0);
        chk($sformatf("bp hold leg c%0d", i), {29'd0, l, e, g}, 32'd1);
        chk($sformatf("bp hold chunks_used c%0d", i), {29'd0, chunks_used}, 32'd4);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) spurious = 1;
      end
      chk("bp ignored pulse", {31'd0, spurious}, 32'd0);
    end

    // Back-to-back: in_valid and out_ready held high across three transactions
    begin
      vec_t bb[3];
      int sent = 0;
      int got = 0;
      bb[0] = '{16'h00F0, 16'h00F1, 1'b0, 3'b100, 3'd4};
      bb[1] = '{16'hA000, 16'h5000, 1'b1, 3'b100, 3'd1};
      bb[2] = '{16'h0F00, 16'h0E00, 1'b0, 3'b001, 3'd2};
      wait_idle();
      out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
        if (c > 0) @(negedge clk);
        if (out_valid) begin
          if (got < 3) begin
            chk($sformatf("b2b%0d leg", got), {29'd0, l, e, g}, {29'd0, bb[got].leg});
            chk($sformatf("b2b%0d chunks_used", got), {29'd0, chunks_used}, {29'd0, bb[got].cu});
          end
          got++;
        end
        if (in_ready) begin
          if (sent < 3) begin
            a = bb[sent].a; b = bb[sent].b; sgn = bb[sent].s; in_valid = 1'b1;
            sent++;
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      chk("b2b result count", got, 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Parametrised, sequential magnitude comparator. It compares two WIDTH-bit operands chunk by chunk, most significant chunk first, and stops early at the first chunk that differs. It supports unsigned and two's-complement signed modes, selected per transaction. It uses valid/ready handshakes on both input and output. It produces registered less/equal/greater flags plus a count of the chunks examined. It is the multi-bit successor of the team's single-bit combinational comparator (l/e/g outputs).

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK; CW = clog2(NCHUNK)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sgn  in  1  1 = two's-complement signed compare, 0 = unsigned.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- l  out  1  A < B.
- e  out  1  A == B.
- g  out  1  A > B.
- chunks_used  out  CW  number of chunks evaluated to reach the decision (1..NCHUNK).

## Operation
- States: IDLE, CMP, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid=1, capture a, b and sgn into internal registers.
  - Load the chunk index with NCHUNK-1 and clear the chunk counter.
  - Go to CMP.
- **Signed handling**
  - When the captured sgn=1, invert bit WIDTH-1 of both captured operands before any chunk is compared.
  - The top chunk is then compared unsigned.
  - No separate signed path is permitted.
- **CMP**, one chunk per cycle:
  - Compare A[idx*CHUNK +: CHUNK] against B[idx*CHUNK +: CHUNK] unsigned, and increment the chunk counter.
  - Chunk A > chunk B: g←1, l←0, e←0; go to DONE.
  - Chunk A < chunk B: l←1, g←0, e←0; go to DONE.
  - Chunks equal and idx==0: e←1, l←0, g←0; go to DONE.
  - Chunks equal and idx>0: idx←idx-1; stay in CMP.
  - chunks_used is loaded with the incremented counter on the same edge the decision is made.
- **DONE**
  - out_valid=1; l, e, g and chunks_used are held stable.
  - On out_ready=1, go to IDLE.
  - While out_ready=0, all outputs hold. in_ready stays 0, so in_valid is ignored.
- **Flag invariants**
  - Exactly one of l/e/g is 1 whenever out_valid=1.
  - In IDLE and CMP, l/e/g/chunks_used keep their last result; consumers use them only while out_valid=1.
- Operand inputs are sampled only on the accept edge. Changes to a, b or sgn afterwards have no effect on the transaction in flight.

## Timing
- **Reset**
  - Asserting rst_n=0 immediately forces: state=IDLE, in_ready=1, out_valid=0, l=e=g=0, chunks_used=0, idx=0.
  - Operand registers are cleared to 0.
  - Reset mid-CMP or mid-DONE abandons the transaction; no result is ever presented for it.
  - The first accept is possible on the first rising edge after rst_n deasserts.
- **Accept**: a transfer occurs on a rising edge with in_valid=1 and in_ready=1; call this edge E0.
- **Latency**: if the decision uses j chunks, the decision is made on edge Ej, and out_valid is high in the cycle after Ej.
  - Best case: 1 cycle after accept.
  - Worst case: NCHUNK cycles after accept (all chunks equal, or only the LSB chunk differs).
- **Release**
  - The result transfer occurs on an edge with out_valid=1 and out_ready=1.
  - in_ready is high in the following cycle.
  - Minimum initiation interval is j+2 cycles.
- Degenerate case CHUNK==WIDTH: every compare decides in CMP on the first cycle, and chunks_used=1.
- No combinational path exists from in_valid or out_ready to in_ready or out_valid. Both are decoded from the state register only.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.

1. Reset: rst_n=0 asserted mid-CMP (a=0x1234, b=0x1234 accepted two edges earlier) -> immediately out_valid=0, l=e=g=0, chunks_used=0, in_ready=1; no result follows.
2. Equality: a=0x1234, b=0x1234, sgn=0, out_ready=1 -> e=1, l=g=0, chunks_used=4, out_valid high 4 cycles after accept.
3. Early exit: a=0x12A4, b=0x12B4, sgn=0 -> l=1, chunks_used=3. Then a=0x9000, b=0x1FFF -> g=1, chunks_used=1, out_valid 1 cycle after accept.
4. Sign mode: a=0x8000, b=0x7FFF with sgn=0 -> g=1; same operands with sgn=1 -> l=1; both with chunks_used=1. Also a=0xFFFF, b=0x0001, sgn=1 -> l=1.
5. Backpressure: a=0x0005, b=0x0003 with out_ready=0 for 5 cycles -> g=1, chunks_used=4, and out_valid held throughout. in_ready=0, and an in_valid pulse with new operands is ignored. After out_ready=1, in_ready returns to 1 on the next cycle.
6. Back-to-back: three transactions driven with in_valid tied high and out_ready tied high -> results appear in order with correct flags, and no transaction is dropped or duplicated.
